// File: rtl/jtag_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the JTAG TDO return path.
// FIFO entry layout, beat header offsets, tkeep patterns and the length mask helper.
package jtag_pkg;

    typedef struct packed {
        logic        last;
        logic [5:0]  length;
        logic [31:0] vector;
    } entry_t;

    localparam int LEN_LSB = 32;
    localparam int SEQ_LSB = 40;

    localparam logic [7:0] KEEP_FULL = 8'hFF;
    localparam logic [7:0] KEEP_LOW  = 8'h0F;

    // Lengths of 32 and above keep every bit of the vector.
    function automatic logic [31:0] len_mask(input logic [5:0] len);
        if (len >= 6'd32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/jtag_tdo_fifo.sv
`timescale 1ns/1ps
// Synchronous show-ahead FIFO holding captured TDO entries.
// Latency: a push is visible at rd_dat_o on the next cycle; push and pop may share a cycle.
// Backpressure: the caller must not push when full (unless popping) or pop when empty.
module jtag_tdo_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wr_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rd_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]     LEVEL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage needs no reset: entries are unreachable until the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign full_o   = (count_q == LEVEL_FULL);
    assign empty_o  = (count_q == '0);
    assign level_o  = count_q;

endmodule

// File: rtl/jtag_tdo_axis.sv
`timescale 1ns/1ps
// Buffers captured TDO vectors and streams them as AXI4-Stream beats (JTAG_TDO_PACK_EN packs two per beat).
// Latency: done in cycle N gives tvalid in cycle N+2 when the output register is free.
// Backpressure: output register stalls on tready=0, FIFO absorbs vectors, overflow is sticky on drops.
module jtag_tdo_axis
    import jtag_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_DATA_LENGTH = 32,
    parameter int C_FIFO_DEPTH         = 8
) (
    input  logic                               m_axis_aclk,
    input  logic                               m_axis_aresetn,
    input  logic                               done,
    input  logic [C_S_AXIS_DATA_LENGTH-1:0]    tdo_vector,
    input  logic [5:0]                         tdo_length,
    input  logic                               tdo_last,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [7:0]                         m_axis_tkeep,
    output logic                               m_axis_tlast,
    output logic                               overflow,
    output logic [$clog2(C_FIFO_DEPTH):0]      fifo_level
);

    entry_t wr_ent;
    entry_t head;
    logic   fifo_full, fifo_empty;
    logic   captured, push, pop, can_load;

    logic                           tvalid_q, tvalid_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [7:0]                     tkeep_q, tkeep_d;
    logic                           tlast_q, tlast_d;
    logic                           overflow_q, overflow_d;

    assign captured = done && (tdo_length != 6'd0);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = captured && (!fifo_full || pop);
    assign can_load = !tvalid_q || m_axis_tready;

    assign wr_ent.last   = tdo_last;
    assign wr_ent.length = tdo_length;
    assign wr_ent.vector = tdo_vector & len_mask(tdo_length);

    assign overflow_d = overflow_q || (captured && fifo_full && !pop);

    jtag_tdo_fifo #(
        .DEPTH (C_FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk_i    (m_axis_aclk),
        .rst_n_i  (m_axis_aresetn),
        .push_i   (push),
        .wr_dat_i (wr_ent),
        .pop_i    (pop),
        .rd_dat_o (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

`ifdef JTAG_TDO_PACK_EN
    logic        half_vld_q, half_vld_d;
    logic [31:0] half_q, half_d;
    logic        unused_len;

    assign unused_len = ^head.length;

    always_comb begin
        pop        = 1'b0;
        half_vld_d = half_vld_q;
        half_d     = half_q;
        tvalid_d   = can_load ? 1'b0 : tvalid_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        if (!fifo_empty) begin
            if (half_vld_q) begin
                if (can_load) begin
                    pop        = 1'b1;
                    half_vld_d = 1'b0;
                    tvalid_d   = 1'b1;
                    tdata_d    = {head.vector, half_q};
                    tkeep_d    = KEEP_FULL;
                    tlast_d    = head.last;
                end
            end else if (head.last) begin
                // First of a pair ends the packet: ship it alone in the low half.
                if (can_load) begin
                    pop      = 1'b1;
                    tvalid_d = 1'b1;
                    tdata_d  = {32'd0, head.vector};
                    tkeep_d  = KEEP_LOW;
                    tlast_d  = 1'b1;
                end
            end else begin
                pop        = 1'b1;
                half_vld_d = 1'b1;
                half_d     = head.vector;
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            half_vld_q <= 1'b0;
            half_q     <= '0;
        end else begin
            half_vld_q <= half_vld_d;
            half_q     <= half_d;
        end
    end
`else
    logic [7:0] seq_q, seq_d;
    logic       fire;

    assign fire  = tvalid_q && m_axis_tready;
    assign seq_d = seq_q + {7'd0, fire};

    always_comb begin
        pop      = 1'b0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        if (can_load) begin
            tvalid_d = !fifo_empty;
            if (!fifo_empty) begin
                pop                       = 1'b1;
                // Stamp with the post-increment count so back-to-back beats number correctly.
                tdata_d                   = '0;
                tdata_d[31:0]             = head.vector;
                tdata_d[LEN_LSB +: 6]     = head.length;
                tdata_d[SEQ_LSB +: 8]     = seq_d;
                tkeep_d                   = KEEP_FULL;
                tlast_d                   = head.last;
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end
`endif

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_jtag_tdo_axis.sv
`timescale 1ns/1ps
// Randomized and directed bench for jtag_tdo_axis against a queue-based reference model.
module tb_jtag_tdo_axis;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        done = 1'b0;
    logic [31:0] tdo_vector = '0;
    logic [5:0]  tdo_length = '0;
    logic        tdo_last = 1'b0;
    logic        tready = 1'b0;
    logic [63:0] tdata;
    logic        tvalid;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        ovf;
    logic [3:0]  level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtag_tdo_axis dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rstn),
        .done           (done),
        .tdo_vector     (tdo_vector),
        .tdo_length     (tdo_length),
        .tdo_last       (tdo_last),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tkeep   (tkeep),
        .m_axis_tlast   (tlast),
        .overflow       (ovf),
        .fifo_level     (level)
    );

    typedef struct {
        logic [31:0] vec;
        int          len;
        bit          last;
    } ment_t;

    ment_t       fq[$];
    bit          m_vld, m_last, m_ovf, m_half_v;
    logic [63:0] m_dat;
    logic [7:0]  m_keep;
    logic [31:0] m_half;
    int          m_seq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_vld = 0; m_last = 0; m_ovf = 0; m_half_v = 0;
        m_dat = '0; m_keep = '0; m_half = '0; m_seq = 0;
    endtask

    // One clock of the reference: the beat that may leave, then what may arrive.
    task automatic model_step(input bit d, input logic [31:0] vec, input int len,
                              input bit last, input bit rdy);
        bit    can_load, popped;
        ment_t e;
        can_load = !m_vld || rdy;
        popped   = 0;
`ifdef JTAG_TDO_PACK_EN
        if (can_load) m_vld = 0;
        if (fq.size() > 0) begin
            if (!m_half_v && !fq[0].last) begin
                m_half   = fq[0].vec;
                m_half_v = 1;
                void'(fq.pop_front());
                popped = 1;
            end else if (can_load) begin
                e = fq.pop_front();
                popped = 1;
                m_vld  = 1;
                m_last = e.last;
                if (m_half_v) begin
                    m_dat = {e.vec, m_half}; m_keep = 8'hFF; m_half_v = 0;
                end else begin
                    m_dat = {32'h0, e.vec}; m_keep = 8'h0F;
                end
            end
        end
`else
        if (m_vld && rdy) m_seq = (m_seq + 1) % 256;
        if (can_load) begin
            m_vld = 0;
            if (fq.size() > 0) begin
                e = fq.pop_front();
                popped = 1;
                m_vld  = 1;
                m_dat  = {16'h0, m_seq[7:0], 2'b00, e.len[5:0], e.vec};
                m_keep = 8'hFF;
                m_last = e.last;
            end
        end
`endif
        if (d && len != 0) begin
            if (fq.size() < DEPTH || popped)
                fq.push_back('{vec: vec & 32'((64'd1 << len) - 64'd1), len: len, last: last});
            else
                m_ovf = 1;
        end
    endtask

    task automatic cmp_all();
        chk("vld", {63'd0, tvalid}, {63'd0, m_vld});
        chk("lvl", {60'd0, level}, 64'(fq.size()));
        chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
        if (m_vld) begin
            chk("dat", tdata, m_dat);
            chk("keep", {56'd0, tkeep}, {56'd0, m_keep});
            chk("last", {63'd0, tlast}, {63'd0, m_last});
        end
    endtask

    task automatic cyc(input bit d, input logic [31:0] vec, input int len,
                       input bit last, input bit rdy);
        done       = d;
        tdo_vector = vec;
        tdo_length = len[5:0];
        tdo_last   = last;
        tready     = rdy;
        @(posedge clk);
        #1;
        model_step(d, vec, len, last, rdy);
        cmp_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst.vld", {63'd0, tvalid}, 64'd0);
        chk("rst.dat", tdata, 64'd0);
        chk("rst.keep", {56'd0, tkeep}, 64'd0);
        chk("rst.last", {63'd0, tlast}, 64'd0);
        chk("rst.ovf", {63'd0, ovf}, 64'd0);
        chk("rst.lvl", {60'd0, level}, 64'd0);
        done = 0; tdo_vector = '0; tdo_length = '0; tdo_last = 0; tready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    int nb;
    logic [63:0] beats[4];
    logic [7:0]  keeps[4];
    logic        lasts[4];

    initial begin
        do_reset();
        cyc(0, 0, 0, 0, 1);
`ifndef JTAG_TDO_PACK_EN
        cyc(1, 32'hDEADBEEF, 32, 1, 1);
        chk("single.early", {63'd0, tvalid}, 64'd0);
        cyc(0, 0, 0, 0, 1);
        chk("single.vld", {63'd0, tvalid}, 64'd1);
        chk("single.dat", tdata, 64'h0000_0020_DEADBEEF);
        chk("single.last", {63'd0, tlast}, 64'd1);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 32'hFFFFFFFF, 5, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("mask.vec", {32'd0, tdata[31:0]}, 64'h1F);
        chk("mask.len", {58'd0, tdata[37:32]}, 64'd5);
        chk("mask.seq", {56'd0, tdata[47:40]}, 64'd1);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 32'h12345678, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("len0.vld", {63'd0, tvalid}, 64'd0);

        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) cyc(1, $urandom, 32, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("bp.ovf", {63'd0, ovf}, 64'd1);
        chk("bp.lvl", {60'd0, level}, 64'd8);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (tvalid) begin
                chk("drain.seq", {56'd0, tdata[47:40]}, 64'(nb));
                nb++;
            end
            cyc(0, 0, 0, 0, 1);
        end
        chk("drain.cnt", 64'(nb), 64'd9);
        chk("drain.ovf", {63'd0, ovf}, 64'd1);

        do_reset();
        nb = 0;
        for (int i = 0; i < 262; i++) begin
            if (tvalid) begin
                if (nb == 256) chk("wrap.seq", {56'd0, tdata[47:40]}, 64'd0);
                nb++;
            end
            cyc(i < 257, $urandom, 32, 0, 1);
        end
        chk("wrap.cnt", 64'(nb), 64'd257);
`else
        do_reset();
        cyc(1, 32'hAAAA0001, 32, 0, 1);
        cyc(1, 32'hBBBB0002, 32, 1, 1);
        cyc(1, 32'hCCCC0003, 32, 1, 1);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (tvalid && nb < 4) begin
                beats[nb] = tdata; keeps[nb] = tkeep; lasts[nb] = tlast;
                nb++;
            end
            cyc(0, 0, 0, 0, 1);
        end
        chk("pack.cnt", 64'(nb), 64'd2);
        chk("pack.b0", beats[0], 64'hBBBB0002_AAAA0001);
        chk("pack.k0", {56'd0, keeps[0]}, 64'hFF);
        chk("pack.l0", {63'd0, lasts[0]}, 64'd1);
        chk("pack.b1", beats[1], 64'h00000000_CCCC0003);
        chk("pack.k1", {56'd0, keeps[1]}, 64'h0F);
        chk("pack.l1", {63'd0, lasts[1]}, 64'd1);
`endif

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, $urandom, 32, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("mid.pre.vld", {63'd0, tvalid}, 64'd1);
        chk("mid.pre.lvl", {60'd0, level}, 64'd3);
        do_reset();
        cyc(1, 32'h0000_00A5, 8, 1, 1);
        cyc(0, 0, 0, 0, 1);
        chk("mid.post.vld", {63'd0, tvalid}, 64'd1);
`ifndef JTAG_TDO_PACK_EN
        chk("mid.post.dat", tdata, 64'h0000_0008_0000_00A5);
`else
        chk("mid.post.dat", tdata, 64'h0000_0000_0000_00A5);
`endif
        repeat (4) cyc(0, 0, 0, 0, 1);

        do_reset();
        repeat (3000) cyc($urandom % 2, $urandom, $urandom_range(0, 32),
                          ($urandom % 4) == 0, ($urandom % 10) < 7);
        repeat (20) cyc(0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
